// File: rtl/jhash_pkg.sv
// Shared definitions for the jhash engine scheduler: state encoding, datapath widths
// and a constant-evaluable clog2.
package jhash_pkg;

   localparam int unsigned JH_DATA_W = 64;
   localparam int unsigned JH_HASH_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } jh_state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/jhash_rr_pick.sv
// Combinational round-robin picker: first set bit of pend searching from rr_ptr+1
// upward, wrapping modulo NCH (NCH need not be a power of two).
module jhash_rr_pick #(
   parameter int unsigned NCH = 4,
   parameter int unsigned CHW = 2
) (
   input  logic [NCH-1:0] pend,
   input  logic [CHW-1:0] rr_ptr,
   output logic           any,
   output logic [CHW-1:0] idx
);

   always_comb begin
      int unsigned c;
      any = 1'b0;
      idx = '0;
      c   = 0;
      for (int unsigned k = 1; k <= NCH; k++) begin
         // rr_ptr < NCH, so a single conditional subtract is the modulo
         c = 32'(rr_ptr) + k;
         if (c >= NCH) c = c - NCH;
         for (int unsigned j = 0; j < NCH; j++) begin
            if (!any && (c == j) && pend[j]) begin
               any = 1'b1;
               idx = CHW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/jhash_sched.sv
// Round-robin scheduler sharing one jhash engine among NCH stream requesters,
// with per-job engine clear, result hand-off over valid/ready and a stall watchdog.
module jhash_sched
   import jhash_pkg::*;
#(
   parameter int unsigned NCH     = 4,
   parameter int unsigned CHW     = 2,
   parameter int unsigned TMO_CYC = 65535
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NCH-1:0]           req_start,
   input  logic [NCH-1:0]           req_src_empty,
   input  logic [NCH-1:0]           req_last,
   input  logic [JH_DATA_W*NCH-1:0] req_fi,
   output logic [NCH-1:0]           req_getn,
   output logic                     eng_rst,
   output logic                     eng_ce,
   output logic                     eng_src_empty,
   output logic                     eng_last,
   output logic [JH_DATA_W-1:0]     eng_fi,
   output logic                     eng_fo_full,
   input  logic                     eng_getn,
   input  logic [JH_HASH_W-1:0]     eng_hash,
   input  logic                     eng_done,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [CHW-1:0]           res_ch,
   output logic [JH_HASH_W-1:0]     res_hash,
   output logic                     res_err,
   output logic                     busy
);

   localparam logic            TMO_EN   = (TMO_CYC != 0);
   localparam logic [15:0]     TMO_LAST = 16'(TMO_CYC - 1);
   localparam logic [CHW-1:0]  PTR_RST  = CHW'(NCH - 1);

   jh_state_e             state_q, state_d;
   logic [NCH-1:0]        pend_q, pend_d, pend_clr;
   logic [CHW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CHW-1:0]        gnt_q, gnt_d;
   logic                  res_valid_q, res_valid_d;
   logic [CHW-1:0]        res_ch_q, res_ch_d;
   logic [JH_HASH_W-1:0]  res_hash_q, res_hash_d;
   logic                  res_err_q, res_err_d;
   logic [15:0]           tmo_cnt_q, tmo_cnt_d;
   logic                  pick_any;
   logic [CHW-1:0]        pick_idx;

   jhash_rr_pick #(.NCH(NCH), .CHW(CHW)) u_pick (
      .pend   (pend_q),
      .rr_ptr (rr_ptr_q),
      .any    (pick_any),
      .idx    (pick_idx)
   );

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      gnt_d         = gnt_q;
      res_valid_d   = res_valid_q;
      res_ch_d      = res_ch_q;
      res_hash_d    = res_hash_q;
      res_err_d     = res_err_q;
      tmo_cnt_d     = tmo_cnt_q;
      pend_clr      = '0;
      eng_rst       = 1'b0;
      eng_ce        = 1'b0;
      eng_src_empty = 1'b1;
      eng_last      = 1'b0;
      eng_fi        = '0;
      req_getn      = '1;

      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               gnt_d   = pick_idx;
               state_d = ST_CLR;
            end
         end
         ST_CLR: begin
            eng_rst   = 1'b1;
            tmo_cnt_d = '0;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            eng_ce    = 1'b1;
            tmo_cnt_d = tmo_cnt_q + 16'd1;
            for (int unsigned i = 0; i < NCH; i++) begin
               if (gnt_q == CHW'(i)) begin
                  eng_src_empty = req_src_empty[i];
                  eng_last      = req_last[i];
                  eng_fi        = req_fi[i*JH_DATA_W +: JH_DATA_W];
                  req_getn[i]   = eng_getn;
               end
            end
            // done takes priority over a same-cycle timeout
            if (eng_done) begin
               res_hash_d  = eng_hash;
               res_ch_d    = gnt_q;
               res_err_d   = 1'b0;
               res_valid_d = 1'b1;
               pend_clr    = NCH'(1) << gnt_q;
               state_d     = ST_DONE;
            end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
               res_hash_d  = '0;
               res_ch_d    = gnt_q;
               res_err_d   = 1'b1;
               res_valid_d = 1'b1;
               pend_clr    = NCH'(1) << gnt_q;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               rr_ptr_d    = gnt_q;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      pend_d = (pend_q & ~pend_clr) | req_start;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pend_q      <= '0;
         rr_ptr_q    <= PTR_RST;
         gnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_ch_q    <= '0;
         res_hash_q  <= '0;
         res_err_q   <= 1'b0;
         tmo_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         res_valid_q <= res_valid_d;
         res_ch_q    <= res_ch_d;
         res_hash_q  <= res_hash_d;
         res_err_q   <= res_err_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   assign res_valid   = res_valid_q;
   assign res_ch      = res_ch_q;
   assign res_hash    = res_hash_q;
   assign res_err     = res_err_q;
   assign eng_fo_full = res_valid_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jhash_sched.sv
// Self-checking bench for jhash_sched: scripted engine stub, scoreboard of expected results.
module tb_jhash_sched;

   logic         clk;
   logic         rst;
   logic [3:0]   req_start, req_src_empty, req_last, req_getn;
   logic [255:0] req_fi;
   logic         eng_rst, eng_ce, eng_src_empty, eng_last, eng_fo_full;
   logic [63:0]  eng_fi;
   logic         eng_getn, eng_done;
   logic [31:0]  eng_hash;
   logic         res_valid, res_ready, res_err, busy;
   logic [1:0]   res_ch;
   logic [31:0]  res_hash;

   typedef struct {
      logic [1:0]  ch;
      logic [31:0] hash;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] fi_words [4];
   int unsigned vectors;
   int unsigned miscompares;

   jhash_sched #(.NCH(4), .CHW(2), .TMO_CYC(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_start     (req_start),
      .req_src_empty (req_src_empty),
      .req_last      (req_last),
      .req_fi        (req_fi),
      .req_getn      (req_getn),
      .eng_rst       (eng_rst),
      .eng_ce        (eng_ce),
      .eng_src_empty (eng_src_empty),
      .eng_last      (eng_last),
      .eng_fi        (eng_fi),
      .eng_fo_full   (eng_fo_full),
      .eng_getn      (eng_getn),
      .eng_hash      (eng_hash),
      .eng_done      (eng_done),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_ch        (res_ch),
      .res_hash      (res_hash),
      .res_err       (res_err),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] fold(input logic [63:0] w);
      return w[63:32] ^ w[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ce(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (eng_ce === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (res_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Engine stub: called on the first RUN cycle; reads nwords then signals done.
   task automatic serve_job(input int nwords, input bit fixed, input logic [31:0] h);
      logic [63:0] fi_seen;
      fi_seen = eng_fi;
      for (int w = 0; w < nwords; w++) begin
         eng_getn = 1'b0;
         tick();
      end
      eng_getn = 1'b1;
      eng_done = 1'b1;
      eng_hash = fixed ? h : fold(fi_seen);
      tick();
      eng_done = 1'b0;
      eng_hash = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      vectors++;
      if ({busy, res_valid, res_err, eng_rst, eng_ce, eng_fo_full} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_flags: busy=%b valid=%b err=%b eng_rst=%b ce=%b fo_full=%b required all 0",
                  busy, res_valid, res_err, eng_rst, eng_ce, eng_fo_full);
      end
      vectors++;
      if ({res_ch, res_hash} !== 34'd0) begin
         miscompares++;
         $display("FAIL reset_res: ch=%0d hash=%h required 0/0", res_ch, res_hash);
      end
      vectors++;
      if ({req_getn, eng_src_empty, eng_last, eng_fi} !== {4'hF, 1'b1, 1'b0, 64'd0}) begin
         miscompares++;
         $display("FAIL reset_outs: getn=%b src_empty=%b last=%b fi=%h required 1111/1/0/0",
                  req_getn, eng_src_empty, eng_last, eng_fi);
      end
   endtask

   task automatic test_single();
      bit   ok;
      exp_t e;
      res_ready     = 1'b0;
      req_src_empty = 4'b1011;
      req_start     = 4'b0100;
      sb.push_back('{2'd2, 32'hDEADBEEF, 1'b0});
      tick();
      req_start = 4'b0000;
      vectors++;
      if ({busy, eng_rst} !== 2'b00) begin
         miscompares++;
         $display("FAIL single_lat: busy=%b eng_rst=%b required 0/0", busy, eng_rst);
      end
      tick();
      vectors++;
      if ({busy, eng_rst, eng_ce} !== 3'b110) begin
         miscompares++;
         $display("FAIL single_clr: busy=%b eng_rst=%b ce=%b required 1/1/0", busy, eng_rst, eng_ce);
      end
      tick();
      vectors++;
      if ({eng_rst, eng_ce, eng_src_empty, eng_fi} !== {1'b0, 1'b1, 1'b0, fi_words[2]}) begin
         miscompares++;
         $display("FAIL single_run: eng_rst=%b ce=%b src_empty=%b fi=%h required 0/1/0/%h",
                  eng_rst, eng_ce, eng_src_empty, eng_fi, fi_words[2]);
      end
      for (int w = 0; w < 3; w++) begin
         eng_getn = 1'b0;
         req_last = (w == 2) ? 4'b0100 : 4'b0000;
         #1;
         vectors++;
         if ({req_getn, eng_last} !== {4'b1011, (w == 2)}) begin
            miscompares++;
            $display("FAIL single_word%0d: getn=%b last=%b required 1011/%0d", w, req_getn, eng_last, (w == 2));
         end
         tick();
      end
      req_last = 4'b0000;
      eng_getn = 1'b1;
      eng_done = 1'b1;
      eng_hash = 32'hDEADBEEF;
      tick();
      eng_done = 1'b0;
      eng_hash = '0;
      wait_valid(ok);
      vectors++;
      if (!ok || sb.size() == 0) begin
         miscompares++;
         $display("FAIL single_res: res_valid=%b required 1", res_valid);
      end else begin
         e = sb.pop_front();
         if ({res_ch, res_hash, res_err} !== {e.ch, e.hash, e.err}) begin
            miscompares++;
            $display("FAIL single_res: ch=%0d hash=%h err=%b required ch=%0d hash=%h err=%b",
                     res_ch, res_hash, res_err, e.ch, e.hash, e.err);
         end
      end
      vectors++;
      if ({eng_ce, eng_fo_full, req_getn, eng_src_empty, eng_fi} !== {1'b0, 1'b1, 4'hF, 1'b1, 64'd0}) begin
         miscompares++;
         $display("FAIL single_done: ce=%b fo_full=%b getn=%b src_empty=%b fi=%h required 0/1/1111/1/0",
                  eng_ce, eng_fo_full, req_getn, eng_src_empty, eng_fi);
      end
      res_ready = 1'b1;
      tick();
      vectors++;
      if ({res_valid, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL single_ack: valid=%b busy=%b required 0/0", res_valid, busy);
      end
      req_src_empty = 4'b0000;
   endtask

   task automatic test_fairness();
      bit   ok;
      exp_t e;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      res_ready = 1'b1;
      req_start = 4'b1011;
      sb.push_back('{2'd0, fold(fi_words[0]), 1'b0});
      sb.push_back('{2'd1, fold(fi_words[1]), 1'b0});
      sb.push_back('{2'd3, fold(fi_words[3]), 1'b0});
      tick();
      req_start = 4'b0000;
      for (int j = 0; j < 5; j++) begin
         wait_ce(ok);
         vectors++;
         if (!ok) begin
            miscompares++;
            $display("FAIL fair_grant%0d: eng_ce=%b required 1", j, eng_ce);
         end else begin
            serve_job(j + 1, 1'b0, 32'd0);
            wait_valid(ok);
            vectors++;
            if (!ok || sb.size() == 0) begin
               miscompares++;
               $display("FAIL fair_res%0d: res_valid=%b required 1", j, res_valid);
            end else begin
               e = sb.pop_front();
               if ({res_ch, res_hash, res_err} !== {e.ch, e.hash, e.err}) begin
                  miscompares++;
                  $display("FAIL fair_res%0d: ch=%0d hash=%h err=%b required ch=%0d hash=%h err=%b",
                           j, res_ch, res_hash, res_err, e.ch, e.hash, e.err);
               end
            end
         end
         if (j == 2) begin
            req_start = 4'b1001;
            sb.push_back('{2'd0, fold(fi_words[0]), 1'b0});
            sb.push_back('{2'd3, fold(fi_words[3]), 1'b0});
            tick();
            req_start = 4'b0000;
         end
      end
   endtask

   task automatic test_backpressure();
      bit   ok;
      exp_t e;
      tick();
      res_ready = 1'b0;
      req_start = 4'b0011;
      sb.push_back('{2'd0, fold(fi_words[0]), 1'b0});
      sb.push_back('{2'd1, fold(fi_words[1]), 1'b0});
      tick();
      req_start = 4'b0000;
      wait_ce(ok);
      serve_job(2, 1'b0, 32'd0);
      wait_valid(ok);
      vectors++;
      if (!ok || sb.size() == 0) begin
         miscompares++;
         $display("FAIL bp_valid: res_valid=%b required 1", res_valid);
      end else begin
         e = sb.pop_front();
         for (int k = 0; k < 10; k++) begin
            vectors++;
            if ({res_valid, res_ch, res_hash, res_err, eng_fo_full, eng_rst, busy} !==
                {1'b1, e.ch, e.hash, e.err, 1'b1, 1'b0, 1'b1}) begin
               miscompares++;
               $display("FAIL bp_hold%0d: valid=%b ch=%0d hash=%h err=%b fo_full=%b eng_rst=%b required 1/%0d/%h/%b/1/0",
                        k, res_valid, res_ch, res_hash, res_err, eng_fo_full, eng_rst, e.ch, e.hash, e.err);
            end
            tick();
         end
      end
      res_ready = 1'b1;
      tick();
      vectors++;
      if ({res_valid, eng_rst} !== 2'b00) begin
         miscompares++;
         $display("FAIL bp_idle: valid=%b eng_rst=%b required 0/0", res_valid, eng_rst);
      end
      tick();
      vectors++;
      if (eng_rst !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_clr: eng_rst=%b required 1", eng_rst);
      end
      wait_ce(ok);
      serve_job(1, 1'b0, 32'd0);
      wait_valid(ok);
      vectors++;
      if (!ok || sb.size() == 0) begin
         miscompares++;
         $display("FAIL bp_res2: res_valid=%b required 1", res_valid);
      end else begin
         e = sb.pop_front();
         if ({res_ch, res_hash, res_err} !== {e.ch, e.hash, e.err}) begin
            miscompares++;
            $display("FAIL bp_res2: ch=%0d hash=%h err=%b required ch=%0d hash=%h err=%b",
                     res_ch, res_hash, res_err, e.ch, e.hash, e.err);
         end
      end
   endtask

   task automatic test_watchdog();
      bit   ok;
      exp_t e;
      req_start = 4'b0010;
      sb.push_back('{2'd1, 32'd0, 1'b1});
      tick();
      req_start = 4'b0000;
      wait_ce(ok);
      for (int k = 1; k <= 8; k++) begin
         vectors++;
         if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_early%0d: res_valid=%b required 0", k, res_valid);
         end
         tick();
      end
      vectors++;
      if (res_valid !== 1'b1 || sb.size() == 0) begin
         miscompares++;
         $display("FAIL wd_res: res_valid=%b required 1", res_valid);
      end else begin
         e = sb.pop_front();
         if ({res_ch, res_hash, res_err, dut.pend_q[1]} !== {e.ch, e.hash, e.err, 1'b0}) begin
            miscompares++;
            $display("FAIL wd_res: ch=%0d hash=%h err=%b pend1=%b required ch=%0d hash=%h err=%b pend1=0",
                     res_ch, res_hash, res_err, dut.pend_q[1], e.ch, e.hash, e.err);
         end
      end
      req_start = 4'b1000;
      sb.push_back('{2'd3, 32'hC0FFEE11, 1'b0});
      tick();
      req_start = 4'b0000;
      wait_ce(ok);
      for (int k = 1; k <= 7; k++) tick();
      eng_done = 1'b1;
      eng_hash = 32'hC0FFEE11;
      tick();
      eng_done = 1'b0;
      eng_hash = '0;
      vectors++;
      if (res_valid !== 1'b1 || sb.size() == 0) begin
         miscompares++;
         $display("FAIL wd_tie: res_valid=%b required 1", res_valid);
      end else begin
         e = sb.pop_front();
         if ({res_ch, res_hash, res_err} !== {e.ch, e.hash, e.err}) begin
            miscompares++;
            $display("FAIL wd_tie: ch=%0d hash=%h err=%b required ch=%0d hash=%h err=%b",
                     res_ch, res_hash, res_err, e.ch, e.hash, e.err);
         end
      end
      tick();
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      req_start = 4'b0110;
      tick();
      req_start = 4'b0000;
      wait_ce(ok);
      eng_getn = 1'b0;
      tick();
      vectors++;
      if (req_getn !== 4'b1101) begin
         miscompares++;
         $display("FAIL rmr_stream: getn=%b required 1101", req_getn);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if ({busy, req_getn, res_valid, dut.pend_q, eng_ce} !== {1'b0, 4'hF, 1'b0, 4'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL rmr_state: busy=%b getn=%b valid=%b pend=%b ce=%b required 0/1111/0/0000/0",
                  busy, req_getn, res_valid, dut.pend_q, eng_ce);
      end
      eng_getn = 1'b1;
      tick();
      tick();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rmr_dropped: busy=%b required 0", busy);
      end
   endtask

   task automatic test_collision();
      bit   ok;
      exp_t e;
      req_start = 4'b0100;
      sb.push_back('{2'd2, 32'h11112222, 1'b0});
      sb.push_back('{2'd2, 32'h33334444, 1'b0});
      tick();
      req_start = 4'b0000;
      wait_ce(ok);
      eng_done  = 1'b1;
      eng_hash  = 32'h11112222;
      req_start = 4'b0100;
      tick();
      eng_done  = 1'b0;
      eng_hash  = '0;
      req_start = 4'b0000;
      vectors++;
      if (dut.pend_q[2] !== 1'b1) begin
         miscompares++;
         $display("FAIL coll_pend: pend2=%b required 1", dut.pend_q[2]);
      end
      for (int j = 0; j < 2; j++) begin
         if (j == 1) begin
            wait_ce(ok);
            serve_job(0, 1'b1, 32'h33334444);
         end
         wait_valid(ok);
         vectors++;
         if (!ok || sb.size() == 0) begin
            miscompares++;
            $display("FAIL coll_res%0d: res_valid=%b required 1", j, res_valid);
         end else begin
            e = sb.pop_front();
            if ({res_ch, res_hash, res_err} !== {e.ch, e.hash, e.err}) begin
               miscompares++;
               $display("FAIL coll_res%0d: ch=%0d hash=%h err=%b required ch=%0d hash=%h err=%b",
                        j, res_ch, res_hash, res_err, e.ch, e.hash, e.err);
            end
         end
      end
      tick();
      tick();
      vectors++;
      if ({busy, dut.pend_q} !== 5'b0) begin
         miscompares++;
         $display("FAIL coll_end: busy=%b pend=%b required 0/0000", busy, dut.pend_q);
      end
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst           = 1'b1;
      req_start     = '0;
      req_src_empty = '0;
      req_last      = '0;
      eng_getn      = 1'b1;
      eng_done      = 1'b0;
      eng_hash      = '0;
      res_ready     = 1'b1;
      for (int i = 0; i < 4; i++) fi_words[i] = {$urandom, $urandom};
      req_fi = {fi_words[3], fi_words[2], fi_words[1], fi_words[0]};

      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_watchdog();
      test_reset_mid_run();
      test_collision();

      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_empty: %0d results outstanding required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
